map_arbiter: RTL and testbench
==============================

# map_arbiter

Owns the 20×15 tile map as synchronous storage and shares it between the tank/bullet requesters and the colour mapper. A fixed display read port serves the colour mapper every cycle. A round-robin, request/acknowledge port serialises tank read-modify-write accesses, such as wall collision lookups and destructible-wall removal. It enforces the tile write rules and latches base-destroyed flags for game-over logic at the top level.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (player1 = index 0, player2 = index 1).
- `MAP_W`, default 20: tiles per row.
- `MAP_H`, default 15: rows.

Ports:
- `Clk`, input, 1 bit: system clock (MAX10_CLK1_50 domain).
- `Reset`, input, 1 bit: synchronous, active-high. One clock; reset is synchronous and active-high.
- `req`, input, `[N_REQ]`: access request, one per requester.
- `we`, input, `[N_REQ]`: 1 = write, 0 = read.
- `addr`, input, `[N_REQ][9]`: tile index, row*MAP_W + col.
- `wdata`, input, `[N_REQ][3]`: tile value to write.
- `ack`, output, `[N_REQ]`: one-cycle completion pulse.
- `rdata`, output, 3 bits: tile value before the access; valid only while some `ack` is high.
- `rej`, output, 1 bit: one-cycle pulse with `ack` when a write was refused.
- `disp_addr`, input, 9 bits: colour-mapper tile index.
- `disp_tile`, output, 3 bits: tile at `disp_addr`, one cycle later.
- `base_hit`, output, 2 bits: sticky. Bit 0 = P1 base (tile 3) hit; bit 1 = P2 base (tile 4) hit.

## Operation
- Tile codes: 0 EMPTY, 1 BORDER, 2 WALL, 3 BASE1, 4 BASE2. Codes 5–7 are illegal.
- Reset loads the default layout from the package constant into all 300 entries. Reset also clears `ack`, `rej`, `rdata`, `disp_tile` and `base_hit` to 0, puts the FSM in IDLE, and sets the round-robin pointer so requester 0 has priority.
- FSM states:
  - IDLE: on each edge, compute eligible = `req & ~ack`. If eligible is nonzero, latch the winner index, its addr/we/wdata, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: perform the access and register `ack[winner]`=1, `rdata` = old tile, and `rej`. Then return to IDLE.
- Round-robin: the winner is the first eligible requester after the last-granted index, modulo N_REQ. The pointer updates only on a grant.
- Write rules, applied against the old tile:
  - BORDER: never modified; `rej`=1.
  - BASE1/BASE2 with wdata=0: tile unchanged; set `base_hit[0]` or `base_hit[1]` respectively; `rej`=0.
  - BASE1/BASE2 with wdata≠0: `rej`=1.
  - EMPTY or WALL with wdata ∈ {0, 2}: store wdata.
  - Any other wdata: `rej`=1 and no change.
- A read never modifies the map and never asserts `rej`.
- Address ≥ MAP_W*MAP_H: `ack` is still issued; `rdata`=1 (BORDER), so out-of-range reads as a wall. A write to such an address is ignored with `rej`=1.
- `base_hit` bits are sticky until `Reset`.

## Timing
- A request sampled in IDLE at edge k produces `ack`, `rdata` and `rej` during the cycle after edge k+1. Latency is 2 cycles.
- The map write commits at edge k+1.
- Requesters must hold `addr`, `we` and `wdata` stable from asserting `req` until `ack`.
- A requester whose `ack` is high is masked at that edge. Holding `req` high yields a new grant no earlier than 3 cycles after the previous one. The other requester may be granted in the ack cycle.
- With both requesters continuously requesting, the grant order alternates 0, 1, 0, 1, …, one access per 2 cycles.
- Dropping `req` before `ack` after the grant has no effect; the access completes anyway.
- Display port: `disp_tile` at edge e+1 equals the map content after any write committed at edge e (write-first). It is always served and has no stalls.
- `Reset` asserted mid-access aborts the access: no `ack`, no write, and the map is reloaded.

## Structure
- Package `tank_pkg` holds:
  - the tile-code enum `tile_t` (3 bits);
  - `MAP_W`, `MAP_H`, `MAP_SIZE`=300;
  - the default layout constant `DEFAULT_MAP[300]`;
  - the FSM state typedef.
- Sub-module `rr_arbiter`, parameterised by N: takes eligible and the last-grant pointer and returns a one-hot winner. It is purely combinational.
- Map storage is a register array so the reset reload is possible.

## Test plan
- Reset, then set `disp_addr`=28 -> `disp_tile`=2 one cycle later. Set `disp_addr`=29 -> 4. Set `disp_addr`=0 -> 1.
- Requester 0 writes 0 to addr 28 (WALL) -> ack[0] 2 cycles later, rdata=2, rej=0. Then `disp_addr`=28 -> 0.
- Both requesters hold `req` high to read addr 21 -> acks alternate 0, 1, 0, 1, each 2 cycles apart. Neither requester starves over 20 grants.
- Write 0 to addr 0 -> rej=1, rdata=1, tile unchanged. Write 0 to addr 269 (BASE1) -> base_hit=2'b01 and stays set. Tile 269 still reads 3.
- Read addr 300 -> ack with rdata=1. Write wdata=3 to addr 21 -> rej=1, tile unchanged.
- Assert `Reset` during BUSY of a write to addr 28 -> no ack. After reset, addr 28 reads 2 and base_hit=0.

Source files
------------

// File: rtl/tank_pkg.sv
// tank_pkg: shared tile codes, map geometry, default layout and arbiter FSM states.
// Contents:
//   tile_t       3-bit tile code (codes 5..7 are never stored)
//   MAP_W/MAP_H  playfield size in tiles; MAP_SIZE = MAP_W*MAP_H
//   DEFAULT_MAP  layout reloaded into the map on reset, row-major
//   state_t      map_arbiter FSM state encoding
package tank_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        BORDER = 3'd1,
        WALL   = 3'd2,
        BASE1  = 3'd3,
        BASE2  = 3'd4
    } tile_t;

    localparam int MAP_W    = 20;
    localparam int MAP_H    = 15;
    localparam int MAP_SIZE = MAP_W * MAP_H;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // Short aliases keep the layout table readable as a 20-column grid.
    localparam tile_t TE = EMPTY;
    localparam tile_t TB = BORDER;
    localparam tile_t TW = WALL;
    localparam tile_t T1 = BASE1;
    localparam tile_t T2 = BASE2;

    // P2 base sits at the top (index 29), P1 base at the bottom (index 269),
    // each shielded by destructible walls.
    localparam tile_t DEFAULT_MAP [MAP_SIZE] = '{
        TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TW, T2, TW, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TW, TW, TW, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TW, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TW, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TW, TW, TW, TE, TE, TE, TE, TE, TE, TW, TW, TW, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TW, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TW, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TW, TW, TW, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TE, TE, TE, TE, TE, TE, TE, TW, T1, TW, TE, TE, TE, TE, TE, TE, TE, TE, TB,
        TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB, TB
    };

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one eligible requester.
// Ports:
//   elig_i  [N]   requesters that may be granted this cycle
//   last_i  [PW]  index of the most recently granted requester
//   gnt_o   [N]   one-hot winner (all zero when nothing is eligible)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0] above;
    logic [N-1:0] hi;
    logic [N-1:0] pick;

    // Prefer the lowest eligible index strictly above last_i; otherwise wrap
    // to the lowest eligible index overall. x & -x isolates the lowest set bit.
    always_comb begin
        above = ~((N'(2) << last_i) - N'(1));
        hi    = elig_i & above;
        pick  = (|hi) ? hi : elig_i;
        gnt_o = pick & (~pick + N'(1));
    end

endmodule

// File: rtl/map_arbiter.sv
// map_arbiter: tile map storage shared by a display read port and round-robin tank RMW port.
// Ports:
//   Clk, Reset       clock, synchronous active-high reset (reloads the default map)
//   req/we/addr/wdata per-requester access request, held stable until ack
//   ack              one-cycle completion pulse for the served requester
//   rdata            tile value before the access, valid while ack is high
//   rej              pulses with ack when a write was refused
//   disp_addr/disp_tile  display read port, one cycle latency, write-first
//   base_hit         sticky {P2 base hit, P1 base hit}
module map_arbiter #(
    parameter int N_REQ = 2,
    parameter int MAP_W = 20,
    parameter int MAP_H = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      we,
    input  logic [N_REQ-1:0][8:0] addr,
    input  logic [N_REQ-1:0][2:0] wdata,
    output logic [N_REQ-1:0]      ack,
    output logic [2:0]            rdata,
    output logic                  rej,
    input  logic [8:0]            disp_addr,
    output logic [2:0]            disp_tile,
    output logic [1:0]            base_hit
);

    import tank_pkg::*;

    localparam int SIZE = MAP_W * MAP_H;
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tile_t            map_q [SIZE];
    state_t           state_q, state_d;
    logic [PW-1:0]    last_q, last_d, win_idx;
    logic [8:0]       addr_q, addr_d;
    logic             we_q, we_d;
    logic [2:0]       wdata_q, wdata_d;
    logic [N_REQ-1:0] ack_q, ack_d, elig, gnt;
    logic [2:0]       rdata_q, rdata_d;
    logic             rej_q, rej_d;
    logic [1:0]       base_hit_q, base_hit_d;
    tile_t            disp_q, old_tile;
    logic             in_range, wr_ok, wr_rej, wr_en;
    logic [1:0]       wr_hit;

    // A requester being acked this cycle sits out one arbitration round.
    assign elig = req & ~ack_q;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .elig_i(elig),
        .last_i(last_q),
        .gnt_o (gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) if (gnt[i]) win_idx = PW'(i);
    end

    // Out-of-range addresses behave like solid border.
    assign in_range = int'(addr_q) < SIZE;
    assign old_tile = in_range ? map_q[addr_q] : BORDER;

    always_comb begin
        wr_ok  = 1'b0;
        wr_rej = 1'b0;
        wr_hit = 2'b00;
        if (!in_range || old_tile == BORDER) wr_rej = 1'b1;
        else if (old_tile == BASE1 || old_tile == BASE2) begin
            // Clearing a base marks it destroyed but leaves the tile in place.
            wr_rej = wdata_q != 3'd0;
            wr_hit = (wdata_q == 3'd0) ? {old_tile == BASE2, old_tile == BASE1} : 2'b00;
        end else if ((old_tile == EMPTY || old_tile == WALL) && (wdata_q == 3'd0 || wdata_q == 3'd2))
            wr_ok = 1'b1;
        else wr_rej = 1'b1;
    end

    // last_q doubles as the index of the requester currently being served.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        rej_d      = 1'b0;
        base_hit_d = base_hit_q;
        wr_en      = 1'b0;
        if (state_q == ST_IDLE) begin
            if (|elig) begin
                state_d = ST_BUSY;
                last_d  = win_idx;
                addr_d  = addr[win_idx];
                we_d    = we[win_idx];
                wdata_d = wdata[win_idx];
            end
        end else begin
            state_d    = ST_IDLE;
            ack_d      = N_REQ'(1) << last_q;
            rdata_d    = old_tile;
            rej_d      = we_q & wr_rej;
            base_hit_d = base_hit_q | (we_q ? wr_hit : 2'b00);
            wr_en      = we_q & wr_ok;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            map_q      <= DEFAULT_MAP;
            state_q    <= ST_IDLE;
            last_q     <= PW'(N_REQ - 1);
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            rej_q      <= 1'b0;
            base_hit_q <= '0;
            disp_q     <= EMPTY;
        end else begin
            if (wr_en) map_q[addr_q] <= tile_t'(wdata_q);
            disp_q     <= (int'(disp_addr) < SIZE) ? map_q[disp_addr] : BORDER;
            state_q    <= state_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rej_q      <= rej_d;
            base_hit_q <= base_hit_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign rej       = rej_q;
    assign disp_tile = disp_q;
    assign base_hit  = base_hit_q;

endmodule

// File: tb/tb_map_arbiter.sv
// tb_map_arbiter: directed, table-driven self-checking bench for map_arbiter.
module tb_map_arbiter;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic [1:0]      req = '0;
    logic [1:0]      we = '0;
    logic [1:0][8:0] addr = '0;
    logic [1:0][2:0] wdata = '0;
    logic [1:0]      ack;
    logic [2:0]      rdata;
    logic            rej;
    logic [8:0]      disp_addr = '0;
    logic [2:0]      disp_tile;
    logic [1:0]      base_hit;

    int total = 0;
    int bad = 0;

    map_arbiter dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .rej(rej), .disp_addr(disp_addr),
        .disp_tile(disp_tile), .base_hit(base_hit)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        int         r;
        logic       w;
        logic [8:0] a;
        logic [2:0] wd;
        logic [2:0] rd;
        logic       rj;
        logic       dchk;
        logic [2:0] dt;
        logic [1:0] hit;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic txn(input int r, input logic w, input logic [8:0] a, input logic [2:0] wd,
                       output int lat, output logic [1:0] ak, output logic [2:0] rd, output logic rj);
        @(negedge Clk);
        req[r] = 1'b1;
        we[r] = w;
        addr[r] = a;
        wdata[r] = wd;
        lat = -1;
        ak = '0;
        rd = 'x;
        rj = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (ack != 2'b00) begin
                lat = c;
                ak = ack;
                rd = rdata;
                rj = rej;
                break;
            end
        end
        req[r] = 1'b0;
    endtask

    task automatic disp_chk(input logic [8:0] a, input logic [2:0] exp, input string name);
        @(negedge Clk);
        disp_addr = a;
        @(negedge Clk);
        chk(name, disp_tile, exp);
    endtask

    initial begin
        int lat, prev, n;
        logic [1:0] ak;
        logic [2:0] rd;
        logic rj;

        //       r  w     addr     wd    rdata rej   dchk  tile  base_hit
        vt[0]  = '{0, 1'b0, 9'd28,  3'd0, 3'd2, 1'b0, 1'b1, 3'd2, 2'b00};
        vt[1]  = '{0, 1'b1, 9'd28,  3'd0, 3'd2, 1'b0, 1'b1, 3'd0, 2'b00};
        vt[2]  = '{1, 1'b0, 9'd28,  3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 2'b00};
        vt[3]  = '{0, 1'b1, 9'd0,   3'd0, 3'd1, 1'b1, 1'b1, 3'd1, 2'b00};
        vt[4]  = '{1, 1'b1, 9'd269, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 2'b01};
        vt[5]  = '{0, 1'b0, 9'd269, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 2'b01};
        vt[6]  = '{0, 1'b0, 9'd300, 3'd0, 3'd1, 1'b0, 1'b0, 3'd0, 2'b01};
        vt[7]  = '{1, 1'b1, 9'd300, 3'd2, 3'd1, 1'b1, 1'b0, 3'd0, 2'b01};
        vt[8]  = '{0, 1'b1, 9'd21,  3'd3, 3'd0, 1'b1, 1'b1, 3'd0, 2'b01};
        vt[9]  = '{1, 1'b1, 9'd21,  3'd2, 3'd0, 1'b0, 1'b1, 3'd2, 2'b01};
        vt[10] = '{0, 1'b1, 9'd22,  3'd4, 3'd0, 1'b1, 1'b1, 3'd0, 2'b01};
        vt[11] = '{1, 1'b1, 9'd29,  3'd0, 3'd4, 1'b0, 1'b1, 3'd4, 2'b11};
        vt[12] = '{0, 1'b1, 9'd269, 3'd2, 3'd3, 1'b1, 1'b1, 3'd3, 2'b11};
        vt[13] = '{1, 1'b1, 9'd21,  3'd7, 3'd2, 1'b1, 1'b1, 3'd2, 2'b11};
        vt[14] = '{0, 1'b1, 9'd21,  3'd0, 3'd2, 1'b0, 1'b1, 3'd0, 2'b11};
        vt[15] = '{1, 1'b0, 9'd279, 3'd0, 3'd1, 1'b0, 1'b1, 3'd1, 2'b11};

        repeat (2) @(negedge Clk);
        chk("rst_ack", ack, 0);
        chk("rst_rej", rej, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_disp", disp_tile, 0);
        chk("rst_hit", base_hit, 0);
        Reset = 1'b0;

        disp_chk(9'd28, 3'd2, "disp28");
        disp_chk(9'd29, 3'd4, "disp29");
        disp_chk(9'd0, 3'd1, "disp0");

        for (int i = 0; i < 16; i++) begin
            txn(vt[i].r, vt[i].w, vt[i].a, vt[i].wd, lat, ak, rd, rj);
            chk($sformatf("v%0d_lat", i), lat, 2);
            chk($sformatf("v%0d_ack", i), ak, 1 << vt[i].r);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d_rej", i), rj, vt[i].rj);
            if (vt[i].dchk) disp_chk(vt[i].a, vt[i].dt, $sformatf("v%0d_disp", i));
            chk($sformatf("v%0d_hit", i), base_hit, vt[i].hit);
        end

        // Both requesters hammer addr 21: acks alternate 0,1,... two cycles apart.
        @(negedge Clk);
        we = 2'b00;
        addr[0] = 9'd21;
        addr[1] = 9'd21;
        req = 2'b11;
        prev = 0;
        n = 0;
        for (int c = 1; c <= 80 && n < 20; c++) begin
            @(negedge Clk);
            if (ack != 2'b00) begin
                chk($sformatf("alt%0d_ack", n), ack, (n % 2 == 0) ? 1 : 2);
                chk($sformatf("alt%0d_gap", n), c - prev, 2);
                chk($sformatf("alt%0d_rdata", n), rdata, 0);
                prev = c;
                n++;
            end
        end
        req = 2'b00;
        chk("alt_count", n, 20);

        // A lone requester holding req is re-granted every third cycle.
        @(negedge Clk);
        addr[0] = 9'd28;
        req[0] = 1'b1;
        prev = 0;
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge Clk);
            if (ack != 2'b00) begin
                chk($sformatf("hold%0d_gap", n), c - prev, (n == 0) ? 2 : 3);
                prev = c;
                n++;
            end
        end
        req[0] = 1'b0;
        chk("hold_count", n, 4);

        // Dropping req right after the grant still completes the access.
        @(negedge Clk);
        @(negedge Clk);
        addr[0] = 9'd29;
        req[0] = 1'b1;
        @(negedge Clk);
        req[0] = 1'b0;
        @(negedge Clk);
        chk("drop_ack", ack, 1);
        chk("drop_rdata", rdata, 4);
        @(negedge Clk);
        chk("drop_ack_pulse", ack, 0);

        // Reset during BUSY of a write aborts it and reloads the map.
        @(negedge Clk);
        we[0] = 1'b1;
        addr[0] = 9'd28;
        wdata[0] = 3'd0;
        req[0] = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        req[0] = 1'b0;
        @(negedge Clk);
        chk("abort_ack", ack, 0);
        chk("abort_rej", rej, 0);
        chk("abort_hit", base_hit, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_ack2", ack, 0);
        disp_chk(9'd28, 3'd2, "abort_disp28");
        txn(0, 1'b0, 9'd28, 3'd0, lat, ak, rd, rj);
        chk("abort_rd_lat", lat, 2);
        chk("abort_rd_rdata", rd, 2);
        chk("abort_rd_hit", base_hit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
